data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder on the slave end of the MEM-stage load/store interface.
- The pipeline presents Address, WriteData, MemWrite, MemRead and Datatype and holds them stable.
- The block stalls the pipeline for a fixed number of cycles, then commits the store or returns the load data with a one-cycle Ready pulse.
- It replaces the single-cycle data memory and adds a stall handshake for slower memory models.

---
 rtl/data_mem_responder.sv | 179 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: stalls the MEM stage for LATENCY cycles, then commits
// the store or returns sign-extended load data with a one-cycle Ready pulse.
// Optional alignment checking is enabled by defining DATA_MEM_ALIGN_CHECK_EN.
module data_mem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [1:0]  Datatype,
    output logic [31:0] ReadData,
    output logic        Stall,
`ifdef DATA_MEM_ALIGN_CHECK_EN
    output logic        AlignError,
`endif
    output logic        Ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_r;
    logic [3:0]          cnt_r;
    logic [ADDR_W+1:0]   addr_r;
    logic [31:0]         wdata_r;
    logic                is_write_r;
    logic [1:0]          dtype_r;

    logic                req_s;
    logic                done_s;
    logic                misaligned_s;
    logic                mem_we_s;
    logic [ADDR_W-1:0]   idx_s;
    logic [1:0]          lane_s;
    logic [31:0]         cur_word_s;
    logic                unused_s;

    // Storage starts zeroed once at time zero; Rst deliberately leaves it untouched.
    logic [31:0] mem_r [DEPTH] = '{default: 32'h0000_0000};

    // Merge right-justified store data into the addressed lanes of the old word.
    function automatic logic [31:0] store_merge(input logic [31:0] old_w,
                                                input logic [31:0] wd,
                                                input logic [1:0]  dt,
                                                input logic [1:0]  lane);
        logic [31:0] res;
        res = old_w;
        case (dt)
            2'b01:   res[{lane[1], 4'b0000} +: 16] = wd[15:0];
            2'b10:   res[{lane, 3'b000} +: 8]      = wd[7:0];
            default: res = wd;
        endcase
        return res;
    endfunction

    // Pull the addressed byte/half into the LSBs and sign-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  dt,
                                                 input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = w[{lane, 3'b000} +: 8];
        h = w[{lane[1], 4'b0000} +: 16];
        case (dt)
            2'b01:   res = {{16{h[15]}}, h};
            2'b10:   res = {{24{b[7]}}, b};
            default: res = w;
        endcase
        return res;
    endfunction

    assign req_s      = MemRead | MemWrite;
    assign idx_s      = addr_r[ADDR_W+1:2];
    assign lane_s     = addr_r[1:0];
    assign cur_word_s = mem_r[idx_s];
    assign done_s     = (state_r == BUSY) && req_s && (cnt_r == 4'd0);
    assign mem_we_s   = done_s && is_write_r && !misaligned_s && !Rst;
    assign unused_s   = ^Address[31:ADDR_W+2];

    // Misalignment classification of the latched request.
    always_comb begin
        misaligned_s = 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
        case (dtype_r)
            2'b01:   misaligned_s = lane_s[0];
            2'b10:   misaligned_s = 1'b0;
            default: misaligned_s = (lane_s != 2'b00);
        endcase
`else
        misaligned_s = 1'b0;
`endif
    end

    // Stall rises combinationally on a new request so the pipeline freezes that same cycle.
    always_comb begin
        Stall = 1'b0;
        case (state_r)
            IDLE:    Stall = req_s;
            BUSY:    Stall = 1'b1;
            default: Stall = 1'b0;
        endcase
    end

    // Storage write port, enabled only on the completing edge of a good store.
    always_ff @(posedge Clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= store_merge(cur_word_s, wdata_r, dtype_r, lane_s);
        end
    end

    // Request FSM with latched operands and registered response outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r    <= IDLE;
            cnt_r      <= 4'd0;
            ReadData   <= 32'h0000_0000;
            Ready      <= 1'b0;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
            is_write_r <= 1'b0;
            dtype_r    <= 2'b00;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            AlignError <= 1'b0;
`endif
        end else begin
            Ready <= 1'b0;
`ifdef DATA_MEM_ALIGN_CHECK_EN
            AlignError <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        addr_r     <= Address[ADDR_W+1:0];
                        wdata_r    <= WriteData;
                        is_write_r <= MemWrite;
                        dtype_r    <= Datatype;
                        cnt_r      <= 4'(LATENCY - 1);
                        state_r    <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (!req_s) begin
                        // Requester withdrew: abandon without committing or responding.
                        cnt_r   <= 4'd0;
                        state_r <= IDLE;
                    end else if (cnt_r == 4'd0) begin
                        if (!is_write_r) begin
                            ReadData <= misaligned_s ? 32'h0000_0000
                                                     : load_extract(cur_word_s, dtype_r, lane_s);
                        end else begin
                            ReadData <= ReadData;
                        end
                        Ready   <= 1'b1;
`ifdef DATA_MEM_ALIGN_CHECK_EN
                        AlignError <= misaligned_s;
`endif
                        state_r <= RESP;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP:    state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder (LATENCY=2, DEPTH=1024): table-driven
// transactions with a load-result scoreboard, plus abort/reset/priority/alignment sequences.
module tb_data_mem_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_write;
    logic        mem_read;
    logic [1:0]  datatype;
    logic [31:0] read_data;
    logic        stall;
    logic        ready;
`ifdef DATA_MEM_ALIGN_CHECK_EN
    logic        align_error;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  dt;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[16];

    data_mem_responder #(.LATENCY(LAT), .DEPTH(1024), .ADDR_W(10)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .Address   (address),
        .WriteData (write_data),
        .MemWrite  (mem_write),
        .MemRead   (mem_read),
        .Datatype  (datatype),
        .ReadData  (read_data),
        .Stall     (stall),
`ifdef DATA_MEM_ALIGN_CHECK_EN
        .AlignError(align_error),
`endif
        .Ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        address    = 32'h0;
        write_data = 32'h0;
        datatype   = 2'b00;
    endtask

    // One full request: drive, count stall cycles until Ready, compare, release.
    task automatic txn(input logic we, input logic re, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] dt,
                       input logic [31:0] exp_rd, input logic exp_align);
        int  stall_cnt;
        bit  done;
        logic [31:0] exp;
        @(negedge clk);
        mem_write = we; mem_read = re; address = addr; write_data = wd; datatype = dt;
        if (re && !we) exp_q.push_back(exp_rd);
        #1;
        stall_cnt = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (ready) begin
                done = 1'b1;
            end else begin
                if (stall) stall_cnt++;
                @(negedge clk); #1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL ready_timeout: addr 0x%08h got no Ready, expected Ready within 40 cycles", addr);
            idle_inputs();
            return;
        end
        chk("stall_cycles", 32'(stall_cnt), 32'(LAT + 1));
        chk("stall_low_at_ready", {31'b0, stall}, 32'h0);
`ifdef DATA_MEM_ALIGN_CHECK_EN
        chk("align_error", {31'b0, align_error}, {31'b0, exp_align});
`else
        if (exp_align) chk("align_expect_unused", 32'h0, 32'h1);
`endif
        if (re && !we) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
            chk("load_data", read_data, exp);
            last_rd = exp;
        end else begin
            chk("store_keeps_rd", read_data, last_rd);
        end
        idle_inputs();
        @(negedge clk); #1;
        chk("ready_one_cycle", {31'b0, ready}, 32'h0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h10, 32'h0,        2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h10, 32'h0,        2'b00, 32'h0};
        vecs[3]  = '{1'b1, 1'b0, 32'h13, 32'h80,       2'b10, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h10, 32'h0,        2'b00, 32'h80000000};
        vecs[5]  = '{1'b0, 1'b1, 32'h13, 32'h0,        2'b10, 32'hFFFFFF80};
        vecs[6]  = '{1'b0, 1'b1, 32'h12, 32'h0,        2'b01, 32'hFFFF8000};
        vecs[7]  = '{1'b1, 1'b0, 32'h20, 32'hAAAAAAAA, 2'b00, 32'h0};
        vecs[8]  = '{1'b1, 1'b0, 32'h22, 32'hFFFF1234, 2'b01, 32'h0};
        vecs[9]  = '{1'b0, 1'b1, 32'h20, 32'h0,        2'b00, 32'h1234AAAA};
        vecs[10] = '{1'b0, 1'b1, 32'h20, 32'h0,        2'b01, 32'hFFFFAAAA};
        vecs[11] = '{1'b0, 1'b1, 32'h21, 32'h0,        2'b10, 32'hFFFFFFAA};
        vecs[12] = '{1'b0, 1'b1, 32'h22, 32'h0,        2'b10, 32'h00000034};
        vecs[13] = '{1'b1, 1'b0, 32'h40, 32'h11223344, 2'b00, 32'h0};
        vecs[14] = '{1'b0, 1'b1, 32'h40, 32'h0,        2'b11, 32'h11223344};
        vecs[15] = '{1'b0, 1'b1, 32'h42, 32'h0,        2'b01, 32'h00001122};

        rst = 1'b1;
        idle_inputs();
        last_rd = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_stall", {31'b0, stall}, 32'h0);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        chk("reset_read_data", read_data, 32'h0);

        for (int i = 0; i < 16; i++) begin
            txn(vecs[i].we, vecs[i].re, vecs[i].addr, vecs[i].wdata, vecs[i].dt,
                vecs[i].exp_rd, 1'b0);
        end

        // Abort: store to 0x40 withdrawn after one BUSY cycle.
        @(negedge clk);
        mem_write = 1'b1; address = 32'h40; write_data = 32'hCAFEF00D; datatype = 2'b00;
        #1;
        chk("abort_stall_idle", {31'b0, stall}, 32'h1);
        @(negedge clk); #1;
        chk("abort_stall_busy", {31'b0, stall}, 32'h1);
        idle_inputs();
        @(negedge clk); #1;
        chk("abort_stall_after", {31'b0, stall}, 32'h0);
        chk("abort_no_ready", {31'b0, ready}, 32'h0);
        @(negedge clk); #1;
        chk("abort_no_late_ready", {31'b0, ready}, 32'h0);
        txn(1'b0, 1'b1, 32'h40, 32'h0, 2'b00, 32'h11223344, 1'b0);

        // Reset on the would-be commit edge of a store to 0x40.
        @(negedge clk);
        mem_write = 1'b1; address = 32'h40; write_data = 32'hBADBAD00; datatype = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("rst_no_ready", {31'b0, ready}, 32'h0);
        rst = 1'b0;
        idle_inputs();
        #1;
        chk("rst_stall_low", {31'b0, stall}, 32'h0);
        chk("rst_read_data", read_data, 32'h0);
        last_rd = 32'h0;
        txn(1'b0, 1'b1, 32'h40, 32'h0, 2'b00, 32'h11223344, 1'b0);

        // Write priority and address wrap: 0x1000 aliases word 0.
        txn(1'b1, 1'b1, 32'h1000, 32'h55, 2'b00, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h0, 32'h0, 2'b00, 32'h55, 1'b0);

`ifdef DATA_MEM_ALIGN_CHECK_EN
        txn(1'b1, 1'b0, 32'h41, 32'hFFFFFFFF, 2'b00, 32'h0, 1'b1);
        txn(1'b0, 1'b1, 32'h40, 32'h0, 2'b00, 32'h11223344, 1'b0);
        txn(1'b0, 1'b1, 32'h42, 32'h0, 2'b01, 32'h00001122, 1'b0);
        txn(1'b0, 1'b1, 32'h43, 32'h0, 2'b01, 32'h00000000, 1'b1);
`else
        txn(1'b0, 1'b1, 32'h43, 32'h0, 2'b01, 32'h00001122, 1'b0);
        txn(1'b1, 1'b0, 32'h45, 32'h00000077, 2'b00, 32'h0, 1'b0);
        txn(1'b0, 1'b1, 32'h44, 32'h0, 2'b00, 32'h00000077, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
